seg_scan_display: RTL and testbench

- Parametrised multiplexed seven-segment scanner; successor to the fixed 8-digit display mux used in the CPU top level.
- Integrates hex decode, refresh prescaler, tear-free frame-synchronous data update, per-digit decimal point, per-digit blink and frame-done pulse.
- Sits between CPU/debug data and the board's anode/cathode pins; replaces the separate per-digit decoder instances plus external 5 kHz clock.

---
 rtl/seg_scan_display.sv | 160 ++++++++++++++++
 tb/tb_seg_scan_display.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner: hex decode, refresh prescaler,
// frame-synchronous (tear-free) data update, per-digit dp and blink,
// and a frame_done pulse when the scan wraps to digit 0.
// Optional build macro SEG_SCAN_LEADING_ZERO_BLANK_EN: digits above the
// most significant nonzero nibble show blank segments (digit 0 never blanks).
module seg_scan_display #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIV          = 20000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  output logic [NUM_DIGITS-1:0]   LEDSEL,
  output logic [7:0]              LEDOUT,
  output logic                    frame_done
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] stg_d, sh_d;
  logic [NUM_DIGITS-1:0]   stg_p, stg_b, sh_p, sh_b;
  logic                    pending;
  logic [FW-1:0]           fcnt;
  logic                    phase;

  logic                    tick, boundary;
  logic [IW-1:0]           idx_nxt;
  logic [4*NUM_DIGITS-1:0] sh_d_nxt;
  logic [NUM_DIGITS-1:0]   sh_p_nxt, sh_b_nxt;
  logic                    phase_nxt;
  logic [3:0]              nib;
  logic                    dp_sel, blink_sel;
  logic [NUM_DIGITS-1:0]   sel_nxt;
  logic [7:0]              seg_nxt;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Scan timing and the frame-boundary view of shadow/blink state; outputs are
  // decoded from the next-state values so a boundary load shows in that frame.
  always_comb begin
    tick      = (presc == PMAX);
    boundary  = tick && (idx == LAST);
    idx_nxt   = idx;
    if (tick) idx_nxt = (idx == LAST) ? '0 : idx + 1'b1;
    sh_d_nxt  = sh_d;
    sh_p_nxt  = sh_p;
    sh_b_nxt  = sh_b;
    if (boundary && load) begin
      sh_d_nxt = data_in;
      sh_p_nxt = dp_in;
      sh_b_nxt = blink_in;
    end else if (boundary && pending) begin
      sh_d_nxt = stg_d;
      sh_p_nxt = stg_p;
      sh_b_nxt = stg_b;
    end
    phase_nxt = (boundary && fcnt == FMAX) ? ~phase : phase;
  end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd, msd_nxt;

  // Most significant nonzero digit of the incoming frame's shadow data
  always_comb begin
    msd_nxt = msd;
    if (boundary) begin
      msd_nxt = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
        if (sh_d_nxt[4*i +: 4] != 4'h0) msd_nxt = IW'(i);
    end
  end

  // Significance is held for the whole frame
  always_ff @(posedge clk or negedge reset)
    if (!reset) msd <= '0;
    else        msd <= msd_nxt;
`endif

  // Select the digit slot being entered and decode its segment pattern
  always_comb begin
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blink_sel = 1'b0;
    sel_nxt   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_nxt == IW'(i)) begin
        nib        = sh_d_nxt[4*i +: 4];
        dp_sel     = sh_p_nxt[i];
        blink_sel  = sh_b_nxt[i];
        sel_nxt[i] = 1'b0;
      end
    end
    seg_nxt = {~dp_sel, hex7(nib)};
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    if (idx_nxt > msd_nxt) seg_nxt[6:0] = 7'h7F;
`endif
    if (blink_sel && phase_nxt) seg_nxt = 8'hFF;
  end

  // Prescaler, scan index, staging/shadow update, blink timing and pin registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc      <= '0;
      idx        <= LAST;
      stg_d      <= '0;
      stg_p      <= '0;
      stg_b      <= '0;
      sh_d       <= '0;
      sh_p       <= '0;
      sh_b       <= '0;
      pending    <= 1'b0;
      fcnt       <= '0;
      phase      <= 1'b0;
      LEDSEL     <= '1;
      LEDOUT     <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      presc      <= tick ? '0 : presc + 1'b1;
      idx        <= idx_nxt;
      sh_d       <= sh_d_nxt;
      sh_p       <= sh_p_nxt;
      sh_b       <= sh_b_nxt;
      phase      <= phase_nxt;
      frame_done <= boundary;
      if (load) begin
        stg_d <= data_in;
        stg_p <= dp_in;
        stg_b <= blink_in;
      end
      // A load on the boundary edge already went straight to shadow
      if (boundary)  pending <= 1'b0;
      else if (load) pending <= 1'b1;
      if (boundary) fcnt <= (fcnt == FMAX) ? '0 : fcnt + 1'b1;
      if (tick) begin
        LEDSEL <= sel_nxt;
        LEDOUT <= seg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display (4 digits, 4 clocks per slot, 2 frames per
// blink half-period). Honours SEG_SCAN_LEADING_ZERO_BLANK_EN when defined.
module tb_seg_scan_display;
  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int BF  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic [4*N-1:0] data_in = '0;
  logic [N-1:0]  dp_in = '0;
  logic [N-1:0]  blink_in = '0;
  logic [N-1:0]  LEDSEL;
  logic [7:0]    LEDOUT;
  logic          frame_done;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  seg_scan_display #(.NUM_DIGITS(N), .DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blink_in(blink_in), .LEDSEL(LEDSEL), .LEDOUT(LEDOUT), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state
  int            m_presc = 0;
  int            m_idx = N - 1;
  int            m_frames = 0;
  bit            m_phase = 1'b0;
  bit            m_pend = 1'b0;
  logic [4*N-1:0] m_stg_d = '0, m_sh_d = '0;
  logic [N-1:0]  m_stg_p = '0, m_stg_b = '0, m_sh_p = '0, m_sh_b = '0;
  logic [N-1:0]  e_sel = '1;
  logic [7:0]    e_out = 8'hFF;
  bit            e_fd = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] render(input int d);
    logic [7:0] r;
    int msd;
    msd = 0;
    for (int i = 0; i < N; i++) if (m_sh_d[4*i +: 4] != 4'h0) msd = i;
    if (m_sh_b[d] && m_phase) return 8'hFF;
    r = HEX[m_sh_d[4*d +: 4]];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    if (d > msd) r = 8'hFF;
`endif
    if (m_sh_p[d]) r[7] = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    m_presc = 0; m_idx = N - 1; m_frames = 0; m_phase = 0; m_pend = 0;
    m_stg_d = '0; m_sh_d = '0; m_stg_p = '0; m_stg_b = '0; m_sh_p = '0; m_sh_b = '0;
    e_sel = '1; e_out = 8'hFF; e_fd = 0;
  endtask

  task automatic model_step();
    bit tick, bnd;
    tick = (m_presc == DIV - 1);
    m_presc = tick ? 0 : m_presc + 1;
    bnd = 0;
    if (tick) begin
      m_idx = (m_idx + 1) % N;
      bnd = (m_idx == 0);
    end
    if (bnd) begin
      if (load) begin
        m_sh_d = data_in; m_sh_p = dp_in; m_sh_b = blink_in;
      end else if (m_pend) begin
        m_sh_d = m_stg_d; m_sh_p = m_stg_p; m_sh_b = m_stg_b;
      end
      m_pend = 0;
      m_frames++;
      if (m_frames == BF) begin
        m_frames = 0;
        m_phase = !m_phase;
      end
    end
    if (load) begin
      m_stg_d = data_in; m_stg_p = dp_in; m_stg_b = blink_in;
      if (!bnd) m_pend = 1;
    end
    if (tick) begin
      e_sel = ~(N'(1) << m_idx);
      e_out = render(m_idx);
    end
    e_fd = bnd;
  endtask

  // Model advances on the same edges as the DUT
  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  // Continuous compare against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("sel", 32'(LEDSEL), 32'(e_sel));
      chk("seg", 32'(LEDOUT), 32'(e_out));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
    end
  end

  task automatic wait_fd();
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    if (!seen) chk("wait_frame_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] p, input logic [N-1:0] b);
    load = 1'b1; data_in = d; dp_in = p; blink_in = b;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    logic [3:0] seq [4];
    logic [7:0] exp_digits [4];
    seq = '{4'hD, 4'hB, 4'h7, 4'hE};

    repeat (2) @(negedge clk);
    chk_on = 1'b1;
    chk("reset_sel", 32'(LEDSEL), 32'hF);
    chk("reset_seg", 32'(LEDOUT), 32'hFF);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("dark_sel", 32'(LEDSEL), 32'hF);
      chk("dark_seg", 32'(LEDOUT), 32'hFF);
    end
    @(negedge clk);
    chk("first_tick_sel", 32'(LEDSEL), 32'hE);
    chk("first_tick_fd", 32'(frame_done), 32'd1);
    for (int s = 0; s < 4; s++) begin
      repeat (DIV) @(negedge clk);
      chk("scan_step_sel", 32'(LEDSEL), 32'(seq[s]));
    end

    // mid-frame load lands at the next boundary
    do_load(16'h1F08, 4'b0001, 4'b0000);
    chk("midframe_unchanged", 32'(LEDOUT), 32'hC0);
    wait_fd();
    exp_digits = '{8'h00, 8'hC0, 8'h8E, 8'hF9};
    chk("load_d0", 32'(LEDOUT), 32'(exp_digits[0]));
    for (int d = 1; d < 4; d++) begin
      repeat (DIV) @(negedge clk);
      chk("load_digit", 32'(LEDOUT), 32'(exp_digits[d]));
    end

    // load exactly on the boundary edge shows in that frame
    wait_fd();
    repeat (N*DIV - 1) @(negedge clk);
    do_load(16'h0003, 4'b0000, 4'b0000);
    chk("bnd_load_fd", 32'(frame_done), 32'd1);
    chk("bnd_load_d0", 32'(LEDOUT), 32'hB0);

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    wait_fd();
    @(negedge clk);
    do_load(16'h0050, 4'b0000, 4'b0000);
    wait_fd();
    exp_digits = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
    chk("lz_d0", 32'(LEDOUT), 32'(exp_digits[0]));
    for (int d = 1; d < 4; d++) begin
      repeat (DIV) @(negedge clk);
      chk("lz_digit", 32'(LEDOUT), 32'(exp_digits[d]));
    end
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_fd();
    exp_digits = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
    chk("lz0_d0", 32'(LEDOUT), 32'(exp_digits[0]));
    for (int d = 1; d < 4; d++) begin
      repeat (DIV) @(negedge clk);
      chk("lz0_digit", 32'(LEDOUT), 32'(exp_digits[d]));
    end
`endif

    // blink on digit 1 over several half-periods, model-checked
    wait_fd();
    @(negedge clk);
    do_load(16'h4321, 4'b0000, 4'b0010);
    repeat (20*N*DIV) @(negedge clk);

    // randomized loads
    for (int c = 0; c < 2500; c++) begin
      load     = ($urandom_range(0, 11) == 0);
      data_in  = 16'($urandom);
      dp_in    = 4'($urandom);
      blink_in = 4'($urandom);
      @(negedge clk);
    end
    load = 1'b0;

    // async reset mid-slot on digit 2
    wait_fd();
    repeat (2*DIV + 1) @(negedge clk);
    chk("pre_reset_sel", 32'(LEDSEL), 32'hB);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_sel", 32'(LEDSEL), 32'hF);
    chk("async_reset_seg", 32'(LEDOUT), 32'hFF);
    chk("async_reset_fd", 32'(frame_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_fd();
    chk("restart_sel", 32'(LEDSEL), 32'hE);
    chk("restart_seg", 32'(LEDOUT), 32'hC0);
    repeat (3*N*DIV) @(negedge clk);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
